gpu_instruction_issuer: RTL and testbench
=========================================

Name: gpu_instruction_issuer

Overview:
- Hardware initiator for the video processor's custom-instruction interface. It drives clk_en/dataA/dataB and consumes done/result, standing in for the Nios processor.
- Game and robot logic push instruction words into an internal FIFO. The issuer sends them one at a time and retries instructions the GPU rejects (result 900).
- It pops instructions the GPU accepts (result 950) and returns frame codes for screen-code query instructions.

Parameters:
- FIFO_DEPTH, 8, instruction FIFO entries (power of two).
- RETRY_GAP, 4, idle cycles with ci_clk_en=0 between a rejected issue and its retry.
- MAX_RETRIES, 255, rejections tolerated before the entry is dropped (8-bit counter).
- TIMEOUT, 16, cycles in ISSUE without ci_done before abort.

Ports:
- clk  in  1  system clock (same 100 MHz domain as the GPU).
- reset  in  1  asynchronous, active-low reset.
- push_valid  in  1  host presents an instruction.
- push_ready  out  1  FIFO not full.
- push_dataA  in  32  instruction word A.
- push_dataB  in  32  instruction word B.
- push_is_query  in  1  entry is a screen-code query.
- ci_clk_en  out  1  custom-instruction enable to the GPU.
- ci_dataA  out  32  to the GPU dataA.
- ci_dataB  out  32  to the GPU dataB.
- ci_done  in  1  GPU done.
- ci_result  in  32  GPU result.
- frame_code  out  32  last returned screen code.
- frame_code_valid  out  1  one-cycle pulse when frame_code updates.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- err_drop  out  1  one-cycle pulse: entry dropped (retries exhausted, timeout, or unknown result).

Behaviour:
- Reset (async, reset=0) clears all state:
  - ci_clk_en=0; ci_dataA=0; ci_dataB=0.
  - frame_code=0; frame_code_valid=0; err_drop=0.
  - FIFO emptied, so fifo_level=0 and push_ready=1; busy=0; FSM forced to IDLE.
  - An in-flight instruction is abandoned. ci_clk_en falls without waiting for a clock edge.
- FIFO:
  - A push is accepted when push_valid & push_ready.
  - Push and pop in the same cycle is legal and leaves fifo_level unchanged. When full, push_ready=0 even if a pop occurs that cycle.
  - Pointers wrap modulo FIFO_DEPTH. The head entry stays in place until popped.
- FSM states: IDLE, ISSUE, GAP.
  - IDLE:
    - ci_clk_en=0. If the FIFO is non-empty, register the head into ci_dataA/ci_dataB and enter ISSUE.
    - ci_clk_en=1 from the next cycle.
    - IDLE always lasts at least one cycle, guaranteeing a low cycle on ci_clk_en between instructions so the GPU's done deasserts.
  - ISSUE:
    - ci_clk_en held 1; timeout counter increments each cycle.
    - On the first cycle with ci_done=1, sample ci_result, drop ci_clk_en the next cycle, and apply the first matching rule:
      - (a) ci_result==900: retry counter +1. If the count reaches MAX_RETRIES, pulse err_drop, pop, go to IDLE; otherwise go to GAP.
      - (b) Query entry (any other value): frame_code<=ci_result, pulse frame_code_valid, pop, go to IDLE.
      - (c) ci_result==950: pop, go to IDLE.
      - (d) Any other value: pulse err_drop, pop, go to IDLE.
    - If the timeout counter reaches TIMEOUT with no ci_done: pulse err_drop, pop, go to IDLE.
  - GAP:
    - ci_clk_en=0 for RETRY_GAP cycles, then re-enter ISSUE with the same head entry and the same data.
    - The retry counter is kept.
- The retry and timeout counters clear on every pop and on entry to ISSUE from IDLE. The timeout counter also clears on entry from GAP.
- Latency: push into an empty FIFO → ci_clk_en high 2 cycles later. GPU done arrives 1 cycle after ci_clk_en → pop/frame_code_valid 1 cycle later.
- ci_done while not in ISSUE is ignored.
- All outputs are registered.

Optional Feature:
- Macro GPU_ISSUER_STATS_EN adds ports stat_issued[15:0], stat_rejected[15:0] and stat_dropped[15:0]:
  - stat_issued counts ISSUE entries.
  - stat_rejected counts 900 results.
  - stat_dropped counts err_drop pulses.
- All three saturate at 16'hFFFF and clear on reset.
- Without the macro the ports and counters are absent and the remaining behaviour is identical.

Decomposition:
- Package gpu_ci_pkg holds:
  - Result constants RES_REJECT=900 and RES_ACCEPT=950.
  - FSM state enum {IDLE, ISSUE, GAP}.
  - Typedef ci_entry_t {is_query, dataB[31:0], dataA[31:0]} (65 bits).
- Sub-module ci_fifo: synchronous FIFO of ci_entry_t with push/pop/level/full/empty. The FSM stays in the top module.

Test Plan:
- Reset, push one entry A=32'h0000_0012, B=32'h0000_0034; GPU model answers 950 → ci_clk_en high 2 cycles after push with ci_dataA=0x12 and ci_dataB=0x34, pop, fifo_level back to 0, busy=0.
- GPU returns 900 twice then 950 → three ISSUE windows, each separated by exactly 4 cycles of ci_clk_en=0, identical data each time, single pop, no err_drop.
- Query entry, GPU returns 32'd123456 → frame_code=123456, frame_code_valid high exactly one cycle, entry popped.
- Push 9 entries back-to-back with the GPU stalled (never done) → push_ready=0 after 8 are accepted; TIMEOUT=16 expiry pulses err_drop and frees one slot.
- MAX_RETRIES=3, GPU always returns 900 → err_drop after the 3rd reject, next entry issued; GPU returns 777 on an entry → err_drop, pop.
- Assert reset mid-ISSUE → ci_clk_en=0 before the next clk edge, fifo_level=0, FSM in IDLE; a subsequent push issues normally.

Source files
------------

// File: rtl/gpu_ci_pkg.sv
// Shared types and constants for the GPU custom-instruction issuer.
package gpu_ci_pkg;

  localparam int unsigned CI_DATA_W = 32;
  localparam int unsigned STAT_W    = 16;

  // GPU result codes: instruction rejected (retry later) / instruction accepted
  localparam logic [CI_DATA_W-1:0] RES_REJECT = 32'd900;
  localparam logic [CI_DATA_W-1:0] RES_ACCEPT = 32'd950;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } ci_state_e;

  // One queued custom instruction (65 bits)
  typedef struct packed {
    logic                 is_query;
    logic [CI_DATA_W-1:0] dataB;
    logic [CI_DATA_W-1:0] dataA;
  } ci_entry_t;

  // Saturating increment for the statistics counters
  function automatic logic [STAT_W-1:0] sat_inc16(input logic [STAT_W-1:0] v, input logic en);
    if (en && (v != {STAT_W{1'b1}})) begin
      return v + STAT_W'(1);
    end
    return v;
  endfunction

endpackage : gpu_ci_pkg

// File: rtl/gpu_instruction_issuer_fifo.sv
// Synchronous FIFO of ci_entry_t; head entry is visible until it is popped.
module ci_fifo
  import gpu_ci_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  ci_entry_t     push_entry,
  input  logic          pop,
  output ci_entry_t     head_c,
  output logic          ready,
  output logic          empty,
  output logic [LW-1:0] level,
  output logic [LW-1:0] level_d_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  ci_entry_t     mem_q [DEPTH];
  ci_entry_t     mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ready_q, ready_d;
  logic          empty_q, empty_d;
  logic          do_push, do_pop;

  // Next-state for storage, pointers, level and the registered full/empty flags
  always_comb begin
    do_push  = push && ready_q;
    do_pop   = pop && !empty_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    ready_d = (level_d != LW'(DEPTH));
    empty_d = (level_d == '0);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b1;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ready_q  <= ready_d;
      empty_q  <= empty_d;
    end
  end

  assign head_c    = mem_q[rd_ptr_q];
  assign ready     = ready_q;
  assign empty     = empty_q;
  assign level     = level_q;
  assign level_d_c = level_d;

endmodule : ci_fifo

// File: rtl/gpu_instruction_issuer.sv
// Custom-instruction initiator for the video processor: queues instruction
// words, issues them one at a time, retries GPU rejects after a quiet gap and
// returns screen codes for query entries.
// Optional build macro GPU_ISSUER_STATS_EN adds saturating issue/reject/drop counters.
module gpu_instruction_issuer
  import gpu_ci_pkg::*;
#(
  parameter  int unsigned FIFO_DEPTH  = 8,
  parameter  int unsigned RETRY_GAP   = 4,
  parameter  int unsigned MAX_RETRIES = 255,
  parameter  int unsigned TIMEOUT     = 16,
  localparam int unsigned LW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [31:0]   push_dataA,
  input  logic [31:0]   push_dataB,
  input  logic          push_is_query,
  output logic          ci_clk_en,
  output logic [31:0]   ci_dataA,
  output logic [31:0]   ci_dataB,
  input  logic          ci_done,
  input  logic [31:0]   ci_result,
  output logic [31:0]   frame_code,
  output logic          frame_code_valid,
  output logic          busy,
  output logic [LW-1:0] fifo_level,
  output logic          err_drop
`ifdef GPU_ISSUER_STATS_EN
  ,
  output logic [15:0]   stat_issued,
  output logic [15:0]   stat_rejected,
  output logic [15:0]   stat_dropped
`endif
);

  localparam int unsigned   TW          = $clog2(TIMEOUT + 1);
  localparam int unsigned   GW          = $clog2(RETRY_GAP + 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(RETRY_GAP - 1);
  localparam logic [7:0]    RETRY_LIMIT = 8'(MAX_RETRIES);

  ci_state_e     state_q, state_d;
  logic          ci_clk_en_q, ci_clk_en_d;
  logic [31:0]   ci_data_a_q, ci_data_a_d;
  logic [31:0]   ci_data_b_q, ci_data_b_d;
  logic [31:0]   frame_code_q, frame_code_d;
  logic          frame_code_valid_q, frame_code_valid_d;
  logic          err_drop_q, err_drop_d;
  logic          busy_q, busy_d;
  logic [7:0]    retry_q, retry_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [GW-1:0] gap_q, gap_d;

  ci_entry_t     push_entry_c;
  ci_entry_t     head_c;
  logic          pop_c;
  logic          fifo_ready;
  logic          fifo_empty;
  logic [LW-1:0] level_d_c;

  assign push_entry_c = '{is_query: push_is_query, dataB: push_dataB, dataA: push_dataA};

  ci_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .push       (push_valid),
    .push_entry (push_entry_c),
    .pop        (pop_c),
    .head_c     (head_c),
    .ready      (fifo_ready),
    .empty      (fifo_empty),
    .level      (fifo_level),
    .level_d_c  (level_d_c)
  );

  // Issue FSM: next state, pop request and next values of all registered outputs
  always_comb begin
    state_d            = state_q;
    ci_clk_en_d        = ci_clk_en_q;
    ci_data_a_d        = ci_data_a_q;
    ci_data_b_d        = ci_data_b_q;
    frame_code_d       = frame_code_q;
    frame_code_valid_d = 1'b0;
    err_drop_d         = 1'b0;
    retry_d            = retry_q;
    tmo_d              = tmo_q;
    gap_d              = gap_q;
    pop_c              = 1'b0;

    case (state_q)
      IDLE: begin
        // one guaranteed low cycle on ci_clk_en so the GPU can drop done
        ci_clk_en_d = 1'b0;
        if (!fifo_empty) begin
          state_d     = ISSUE;
          ci_clk_en_d = 1'b1;
          ci_data_a_d = head_c.dataA;
          ci_data_b_d = head_c.dataB;
          retry_d     = '0;
          tmo_d       = '0;
        end
      end

      ISSUE: begin
        if (ci_done) begin
          ci_clk_en_d = 1'b0;
          if (ci_result == RES_REJECT) begin
            if (retry_q + 8'd1 == RETRY_LIMIT) begin
              err_drop_d = 1'b1;
              pop_c      = 1'b1;
              state_d    = IDLE;
            end else begin
              retry_d = retry_q + 8'd1;
              gap_d   = '0;
              state_d = GAP;
            end
          end else if (head_c.is_query) begin
            frame_code_d       = ci_result;
            frame_code_valid_d = 1'b1;
            pop_c              = 1'b1;
            state_d            = IDLE;
          end else if (ci_result == RES_ACCEPT) begin
            pop_c   = 1'b1;
            state_d = IDLE;
          end else begin
            err_drop_d = 1'b1;
            pop_c      = 1'b1;
            state_d    = IDLE;
          end
        end else if (tmo_q == TMO_LAST) begin
          ci_clk_en_d = 1'b0;
          err_drop_d  = 1'b1;
          pop_c       = 1'b1;
          state_d     = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      GAP: begin
        // same head entry and data go out again; retry count is kept
        if (gap_q == GAP_LAST) begin
          state_d     = ISSUE;
          ci_clk_en_d = 1'b1;
          tmo_d       = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      default: begin
        state_d     = IDLE;
        ci_clk_en_d = 1'b0;
      end
    endcase

    if (pop_c) begin
      retry_d = '0;
      tmo_d   = '0;
    end

    busy_d = (level_d_c != '0) || (state_d != IDLE);
  end

  // FSM and output registers; reset drops ci_clk_en immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q            <= IDLE;
      ci_clk_en_q        <= 1'b0;
      ci_data_a_q        <= '0;
      ci_data_b_q        <= '0;
      frame_code_q       <= '0;
      frame_code_valid_q <= 1'b0;
      err_drop_q         <= 1'b0;
      busy_q             <= 1'b0;
      retry_q            <= '0;
      tmo_q              <= '0;
      gap_q              <= '0;
    end else begin
      state_q            <= state_d;
      ci_clk_en_q        <= ci_clk_en_d;
      ci_data_a_q        <= ci_data_a_d;
      ci_data_b_q        <= ci_data_b_d;
      frame_code_q       <= frame_code_d;
      frame_code_valid_q <= frame_code_valid_d;
      err_drop_q         <= err_drop_d;
      busy_q             <= busy_d;
      retry_q            <= retry_d;
      tmo_q              <= tmo_d;
      gap_q              <= gap_d;
    end
  end

  assign push_ready       = fifo_ready;
  assign ci_clk_en        = ci_clk_en_q;
  assign ci_dataA         = ci_data_a_q;
  assign ci_dataB         = ci_data_b_q;
  assign frame_code       = frame_code_q;
  assign frame_code_valid = frame_code_valid_q;
  assign err_drop         = err_drop_q;
  assign busy             = busy_q;

`ifdef GPU_ISSUER_STATS_EN
  logic [15:0] stat_issued_q, stat_issued_d;
  logic [15:0] stat_rejected_q, stat_rejected_d;
  logic [15:0] stat_dropped_q, stat_dropped_d;

  // Saturating event counters: ISSUE entries, 900 results, dropped entries
  always_comb begin
    stat_issued_d   = sat_inc16(stat_issued_q, (state_d == ISSUE) && (state_q != ISSUE));
    stat_rejected_d = sat_inc16(stat_rejected_q,
                                (state_q == ISSUE) && ci_done && (ci_result == RES_REJECT));
    stat_dropped_d  = sat_inc16(stat_dropped_q, err_drop_d);
  end

  // Statistics registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_issued_q   <= '0;
      stat_rejected_q <= '0;
      stat_dropped_q  <= '0;
    end else begin
      stat_issued_q   <= stat_issued_d;
      stat_rejected_q <= stat_rejected_d;
      stat_dropped_q  <= stat_dropped_d;
    end
  end

  assign stat_issued   = stat_issued_q;
  assign stat_rejected = stat_rejected_q;
  assign stat_dropped  = stat_dropped_q;
`endif

endmodule : gpu_instruction_issuer

// File: tb/tb_gpu_instruction_issuer.sv
// Scoreboard bench for gpu_instruction_issuer with a behavioural GPU responder.
module tb_gpu_instruction_issuer;

  localparam int unsigned LW = 4;

  localparam int EV_ISSUE = 0;
  localparam int EV_FRAME = 1;
  localparam int EV_DROP  = 2;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          push_valid;
  logic          push_ready;
  logic [31:0]   push_dataA;
  logic [31:0]   push_dataB;
  logic          push_is_query;
  logic          ci_clk_en;
  logic [31:0]   ci_dataA;
  logic [31:0]   ci_dataB;
  logic          ci_done = 1'b0;
  logic [31:0]   ci_result = 32'd0;
  logic [31:0]   frame_code;
  logic          frame_code_valid;
  logic          busy;
  logic [LW-1:0] fifo_level;
  logic          err_drop;
`ifdef GPU_ISSUER_STATS_EN
  logic [15:0]   stat_issued;
  logic [15:0]   stat_rejected;
  logic [15:0]   stat_dropped;
`endif

  int          n_total = 0;
  int          n_bad   = 0;
  ev_t         exp_q[$];
  logic [31:0] gpu_q[$];
  logic        gpu_stall = 1'b0;
  logic        gpu_seen  = 1'b0;
  logic        prev_en   = 1'b0;
  int          fcv_cnt   = 0;
  int          drop_cnt  = 0;

  gpu_instruction_issuer #(
    .FIFO_DEPTH  (8),
    .RETRY_GAP   (4),
    .MAX_RETRIES (3),
    .TIMEOUT     (16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .push_valid       (push_valid),
    .push_ready       (push_ready),
    .push_dataA       (push_dataA),
    .push_dataB       (push_dataB),
    .push_is_query    (push_is_query),
    .ci_clk_en        (ci_clk_en),
    .ci_dataA         (ci_dataA),
    .ci_dataB         (ci_dataB),
    .ci_done          (ci_done),
    .ci_result        (ci_result),
    .frame_code       (frame_code),
    .frame_code_valid (frame_code_valid),
    .busy             (busy),
    .fifo_level       (fifo_level),
    .err_drop         (err_drop)
`ifdef GPU_ISSUER_STATS_EN
    ,
    .stat_issued      (stat_issued),
    .stat_rejected    (stat_rejected),
    .stat_dropped     (stat_dropped)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    e.kind = kind;
    e.a    = a;
    e.b    = b;
    exp_q.push_back(e);
  endtask

  task automatic got_ev(input int kind, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    n_total++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind=%0d a=%0h b=%0h, none expected at %0t",
               kind, a, b, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.a !== a || e.b !== b) begin
        n_bad++;
        $display("FAIL event: got kind=%0d a=%0h b=%0h expected kind=%0d a=%0h b=%0h at %0t",
                 kind, a, b, e.kind, e.a, e.b, $time);
      end
    end
  endtask

  // GPU model: done one cycle after ci_clk_en rises, until clk_en drops
  always @(negedge clk) begin
    if (!reset) begin
      ci_done  = 1'b0;
      gpu_seen = 1'b0;
    end else if (ci_clk_en) begin
      if (gpu_seen && !ci_done && !gpu_stall) begin
        ci_done   = 1'b1;
        ci_result = (gpu_q.size() != 0) ? gpu_q.pop_front() : 32'd950;
      end else begin
        ci_done = 1'b0;
      end
      gpu_seen = 1'b1;
    end else begin
      ci_done  = 1'b0;
      gpu_seen = 1'b0;
    end
  end

  // Monitor: issue starts, frame codes and drops checked against the scoreboard
  always @(negedge clk) begin
    if (reset) begin
      if (ci_clk_en && !prev_en) got_ev(EV_ISSUE, ci_dataA, ci_dataB);
      if (frame_code_valid) begin
        fcv_cnt++;
        got_ev(EV_FRAME, frame_code, 32'd0);
      end
      if (err_drop) begin
        drop_cnt++;
        got_ev(EV_DROP, 32'd0, 32'd0);
      end
    end
    prev_en = ci_clk_en;
  end

  task automatic do_push(input logic [31:0] a, input logic [31:0] b, input logic q);
    @(negedge clk);
    push_valid    = 1'b1;
    push_dataA    = a;
    push_dataB    = b;
    push_is_query = q;
    @(negedge clk);
    push_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy && !ci_clk_en) break;
    end
    chk({name, "_idle"}, 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int rises;
    int low;
    int en_cnt;
    int d0;
    logic p;
    logic dropped;

    push_valid    = 1'b0;
    push_dataA    = 32'd0;
    push_dataB    = 32'd0;
    push_is_query = 1'b0;

    // reset values
    #1 reset = 1'b0;
    #11;
    chk("rst_clk_en", 32'(ci_clk_en), 32'd0);
    chk("rst_dataA", ci_dataA, 32'd0);
    chk("rst_dataB", ci_dataB, 32'd0);
    chk("rst_frame_code", frame_code, 32'd0);
    chk("rst_fcv", 32'(frame_code_valid), 32'd0);
    chk("rst_err_drop", 32'(err_drop), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_push_ready", 32'(push_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // single accepted instruction, latency check
    expect_ev(EV_ISSUE, 32'h12, 32'h34);
    do_push(32'h0000_0012, 32'h0000_0034, 1'b0);
    chk("t1_clk_en_c1", 32'(ci_clk_en), 32'd0);
    chk("t1_level_c1", 32'(fifo_level), 32'd1);
    chk("t1_busy_c1", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t1_clk_en_c2", 32'(ci_clk_en), 32'd1);
    chk("t1_dataA", ci_dataA, 32'h12);
    chk("t1_dataB", ci_dataB, 32'h34);
    wait_idle("t1");
    chk("t1_level_end", 32'(fifo_level), 32'd0);

    // two rejects then accept: three windows separated by 4 low cycles
    gpu_q.push_back(32'd900);
    gpu_q.push_back(32'd900);
    gpu_q.push_back(32'd950);
    repeat (3) expect_ev(EV_ISSUE, 32'h21, 32'h43);
    d0 = drop_cnt;
    do_push(32'h0000_0021, 32'h0000_0043, 1'b0);
    rises = 0;
    low   = 0;
    p     = ci_clk_en;
    for (int i = 0; i < 100 && !(rises > 0 && !busy); i++) begin
      @(negedge clk);
      if (ci_clk_en) begin
        if (!p) begin
          rises++;
          if (rises > 1) chk($sformatf("t2_gap_%0d", rises - 1), 32'(low), 32'd4);
        end
        low = 0;
      end else begin
        low++;
      end
      p = ci_clk_en;
    end
    @(negedge clk);
    chk("t2_windows", 32'(rises), 32'd3);
    chk("t2_no_drop", 32'(drop_cnt - d0), 32'd0);
    chk("t2_level_end", 32'(fifo_level), 32'd0);

    // screen-code query
    gpu_q.push_back(32'd123456);
    expect_ev(EV_ISSUE, 32'h0000_0055, 32'h0000_0066);
    expect_ev(EV_FRAME, 32'd123456, 32'd0);
    d0 = fcv_cnt;
    do_push(32'h0000_0055, 32'h0000_0066, 1'b1);
    wait_idle("t3");
    chk("t3_frame_code", frame_code, 32'd123456);
    chk("t3_fcv_cycles", 32'(fcv_cnt - d0), 32'd1);
    chk("t3_level_end", 32'(fifo_level), 32'd0);

    // fill FIFO with the GPU stalled; head times out after 16 issue cycles
    gpu_stall = 1'b1;
    expect_ev(EV_ISSUE, 32'h100, 32'h200);
    expect_ev(EV_DROP, 32'd0, 32'd0);
    for (int i = 1; i < 8; i++) expect_ev(EV_ISSUE, 32'h100 + 32'(i), 32'h200 + 32'(i));
    en_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (ci_clk_en) en_cnt++;
      push_valid    = 1'b1;
      push_dataA    = 32'h100 + 32'(i);
      push_dataB    = 32'h200 + 32'(i);
      push_is_query = 1'b0;
      chk($sformatf("t4_push_ready_%0d", i), 32'(push_ready), (i < 8) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    if (ci_clk_en) en_cnt++;
    push_valid = 1'b0;
    chk("t4_level_full", 32'(fifo_level), 32'd8);
    dropped = 1'b0;
    for (int i = 0; i < 40 && !dropped; i++) begin
      @(negedge clk);
      if (err_drop) begin
        dropped = 1'b1;
        chk("t4_timeout_cycles", 32'(en_cnt), 32'd16);
        chk("t4_clk_en_at_drop", 32'(ci_clk_en), 32'd0);
        chk("t4_level_after_drop", 32'(fifo_level), 32'd7);
        chk("t4_ready_after_drop", 32'(push_ready), 32'd1);
        gpu_stall = 1'b0;
      end else if (ci_clk_en) begin
        en_cnt++;
      end
    end
    chk("t4_drop_seen", 32'(dropped), 32'd1);
    gpu_stall = 1'b0;
    wait_idle("t4");
    chk("t4_level_end", 32'(fifo_level), 32'd0);

    // retries exhausted (MAX_RETRIES=3), then an unknown result
    repeat (3) gpu_q.push_back(32'd900);
    gpu_q.push_back(32'd777);
    repeat (3) expect_ev(EV_ISSUE, 32'h0000_0501, 32'h0000_0502);
    expect_ev(EV_DROP, 32'd0, 32'd0);
    expect_ev(EV_ISSUE, 32'h0000_0503, 32'h0000_0504);
    expect_ev(EV_DROP, 32'd0, 32'd0);
    d0 = drop_cnt;
    do_push(32'h0000_0501, 32'h0000_0502, 1'b0);
    do_push(32'h0000_0503, 32'h0000_0504, 1'b0);
    wait_idle("t5");
    chk("t5_drops", 32'(drop_cnt - d0), 32'd2);
    chk("t5_level_end", 32'(fifo_level), 32'd0);

    // reset in the middle of an issue
    gpu_stall = 1'b1;
    expect_ev(EV_ISSUE, 32'h0000_0601, 32'h0000_0602);
    do_push(32'h0000_0601, 32'h0000_0602, 1'b0);
    do_push(32'h0000_0603, 32'h0000_0604, 1'b0);
    for (int i = 0; i < 10 && !ci_clk_en; i++) @(negedge clk);
    chk("t6_issuing", 32'(ci_clk_en), 32'd1);
    chk("t6_level_pre", 32'(fifo_level), 32'd2);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_clk_en", 32'(ci_clk_en), 32'd0);
    chk("t6_dataA", ci_dataA, 32'd0);
    chk("t6_level", 32'(fifo_level), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_push_ready", 32'(push_ready), 32'd1);
    chk("t6_frame_code", frame_code, 32'd0);
    @(negedge clk);
    reset     = 1'b1;
    gpu_stall = 1'b0;
    expect_ev(EV_ISSUE, 32'h0000_0701, 32'h0000_0702);
    do_push(32'h0000_0701, 32'h0000_0702, 1'b0);
    @(negedge clk);
    chk("t6_reissue_clk_en", 32'(ci_clk_en), 32'd1);
    wait_idle("t6");
    chk("t6_level_end", 32'(fifo_level), 32'd0);

    repeat (2) @(negedge clk);
    chk("leftover_events", 32'(exp_q.size()), 32'd0);
    chk("leftover_gpu_results", 32'(gpu_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule : tb_gpu_instruction_issuer
